// File: rtl/mmss_scan_display.sv
// Multiplexed 4-digit MM:SS driver for a common-anode 7-segment display.
// Inputs are snapshotted once per frame so a frame never shows mixed values.
module mmss_scan_display #(
   parameter int REFRESH_DIV = 1000,
   parameter int BLANK_CYC   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [5:0]    snap_min;
   logic [5:0]    snap_sec;
   logic          presc_tc;
   logic          capture;
   logic [3:0]    digit;
   logic [3:0]    an_nxt;

   assign presc_tc = (presc == PRESC_TC);
   assign capture  = presc_tc && (idx == 2'd3);

   function automatic logic [5:0] sat59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      logic [5:0] q;
      q = v / 6'd10;
      return q[3:0];
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v);
      logic [5:0] r;
      r = v % 6'd10;
      return r[3:0];
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h40;
         4'd1:    c = 7'h79;
         4'd2:    c = 7'h24;
         4'd3:    c = 7'h30;
         4'd4:    c = 7'h19;
         4'd5:    c = 7'h12;
         4'd6:    c = 7'h02;
         4'd7:    c = 7'h78;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h10;
         default: c = 7'h7F;
      endcase
      return c;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         idx        <= 2'd0;
         snap_min   <= 6'd0;
         snap_sec   <= 6'd0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= capture;
         if (presc_tc) begin
            presc <= '0;
            idx   <= idx + 2'd1;
         end else begin
            presc <= presc + 1'b1;
         end
         // Capture lands on the same edge that starts slot 0 of the next frame.
         if (capture) begin
            snap_min <= sat59(min);
            snap_sec <= sat59(sec);
         end
      end
   end

   always_comb begin
      digit = 4'd0;
      case (idx)
         2'd0: digit = ones_of(snap_sec);
         2'd1: digit = tens_of(snap_sec);
         2'd2: digit = ones_of(snap_min);
         2'd3: digit = tens_of(snap_min);
         default: digit = 4'd0;
      endcase
   end

   always_comb begin
      an_nxt = 4'hF;
      if (presc >= BLANK_END) an_nxt[idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_code(digit);
         dp  <= (idx != 2'd2);
      end
   end

endmodule

// File: tb/tb_mmss_scan_display.sv
// Scoreboard bench for mmss_scan_display: expected per-cycle outputs are queued
// per frame and popped at each falling edge.
module tb_mmss_scan_display;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] min, sec;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_tick;

   logic       rst_long_n;
   logic [5:0] min_l, sec_l;
   logic [6:0] seg_l;
   logic       dp_l;
   logic [3:0] an_l;
   logic       ft_l;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mmss_scan_display #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .min(min), .sec(sec),
      .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

   mmss_scan_display #(.REFRESH_DIV(1000), .BLANK_CYC(8)) dut_long (
      .clk(clk), .rst_n(rst_long_n), .min(min_l), .sec(sec_l),
      .seg(seg_l), .dp(dp_l), .an(an_l), .frame_tick(ft_l));

   function automatic logic [6:0] code_of(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Queue one 16-cycle frame displaying mm:ss (values already as displayed).
   task automatic expect_frame(input int mm, input int ss);
      int d [4];
      exp_t e;
      d[0] = ss % 10; d[1] = ss / 10; d[2] = mm % 10; d[3] = mm / 10;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            e.an  = 4'hF;
            if (c >= 1) e.an[s] = 1'b0;
            e.seg = code_of(d[s]);
            e.dp  = (s == 2) ? 1'b0 : 1'b1;
            e.ft  = (s == 3 && c == 3) ? 1'b1 : 1'b0;
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_samples(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_empty: DUT output with no expected entry at %0t", $time);
            continue;
         end
         n_pass++;
         e = sb.pop_front();
         n_checks++;
         if (an !== e.an) $display("FAIL an @%0t: got %b want %b", $time, an, e.an);
         else n_pass++;
         n_checks++;
         if (seg !== e.seg) $display("FAIL seg @%0t: got %h want %h", $time, seg, e.seg);
         else n_pass++;
         n_checks++;
         if (dp !== e.dp) $display("FAIL dp @%0t: got %b want %b", $time, dp, e.dp);
         else n_pass++;
         n_checks++;
         if (frame_tick !== e.ft)
            $display("FAIL frame_tick @%0t: got %b want %b", $time, frame_tick, e.ft);
         else n_pass++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_checks++;
      if (an !== 4'hF) $display("FAIL %s_an: got %b want 1111", tag, an);
      else n_pass++;
      n_checks++;
      if (seg !== 7'h7F) $display("FAIL %s_seg: got %h want 7f", tag, seg);
      else n_pass++;
      n_checks++;
      if (dp !== 1'b1) $display("FAIL %s_dp: got %b want 1", tag, dp);
      else n_pass++;
      n_checks++;
      if (frame_tick !== 1'b0) $display("FAIL %s_ft: got %b want 0", tag, frame_tick);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
   endtask

   task automatic test_first_frame();
      rst_n = 1'b1;
      expect_frame(0, 0);
      run_samples(5);
      min = 6'd12; sec = 6'd34;
      run_samples(11);
   endtask

   task automatic test_capture();
      expect_frame(12, 34);
      run_samples(16);
   endtask

   task automatic test_mid_frame_change();
      expect_frame(12, 34);
      run_samples(6);
      sec = 6'd35;
      run_samples(10);
      expect_frame(12, 35);
      run_samples(16);
   endtask

   task automatic test_saturation();
      min = 6'd63; sec = 6'd60;
      expect_frame(12, 35);
      run_samples(16);
      expect_frame(59, 59);
      run_samples(16);
   endtask

   task automatic test_reset_mid();
      expect_frame(59, 59);
      run_samples(10);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrst");
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_frame(0, 0);
      run_samples(16);
      expect_frame(59, 59);
      run_samples(16);
   endtask

   task automatic test_long_div();
      int an_low [4];
      int dp_low, first_dp, ft_cnt, ft_pos;
      for (int i = 0; i < 4; i++) an_low[i] = 0;
      dp_low = 0; first_dp = 0; ft_cnt = 0; ft_pos = 0;
      rst_long_n = 1'b1;
      for (int k = 1; k <= 4000; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (an_l[i] === 1'b0) an_low[i]++;
         if (dp_l === 1'b0) begin
            dp_low++;
            if (first_dp == 0) first_dp = k;
         end
         if (ft_l === 1'b1) begin
            ft_cnt++;
            ft_pos = k;
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (an_low[i] != 992) $display("FAIL long_an%0d_low: got %0d want 992", i, an_low[i]);
         else n_pass++;
      end
      n_checks++;
      if (dp_low != 1000) $display("FAIL long_dp_low: got %0d want 1000", dp_low);
      else n_pass++;
      n_checks++;
      if (first_dp != 2001) $display("FAIL long_dp_start: got %0d want 2001", first_dp);
      else n_pass++;
      n_checks++;
      if (ft_cnt != 1) $display("FAIL long_ft_count: got %0d want 1", ft_cnt);
      else n_pass++;
      n_checks++;
      if (ft_pos != 4000) $display("FAIL long_ft_pos: got %0d want 4000", ft_pos);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; rst_long_n = 1'b0;
      min = 6'd0; sec = 6'd0;
      min_l = 6'd7; sec_l = 6'd42;
      test_reset();
      test_first_frame();
      test_capture();
      test_mid_frame_change();
      test_saturation();
      test_reset_mid();
      test_long_div();
      n_checks++;
      if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
